// File: rtl/mem_sched_mc.sv
// ---------------------------------------------------------------------------
// mem_sched_mc
//  Multi-channel DDR application-port command scheduler. It arbitrates
//  NUM_WR_CH write requesters and NUM_RD_CH read requesters onto a single
//  MIG-style app interface. Each read grant issues RD_BURST read commands.
//  Each accepted read burst records its channel in a tag FIFO, and every
//  returning read beat is labelled with the channel at the FIFO head.
//
//  Ports
//   clk, rst_n       clock (posedge) / asynchronous active-low reset
//   freeze           1 = issue nothing; scheduler state and counters hold
//   w_req, r_req     per-channel level requests
//   mem_app_rdy      controller accepts a command this cycle
//   mem_wr_rdy       controller write-data FIFO ready
//   mem_rd_rdy       read data valid from the controller
//   app_en, cmd      command valid / opcode (000 write, 001 read)
//   mem_wr           write-data enable
//   mem_rd           read beat accepted
//   wr_grant         one-hot pulse: write command accepted for a channel
//   rd_grant         one-hot pulse: last read command of a burst accepted
//   rd_addr_num      index of the read command currently being issued
//   rd_valid_num     beat index inside the current returning burst
//   rd_valid_ch      channel that owns the current returning beat
//   rd_last          last beat of a returning burst
//   rd_err           sticky: read data arrived with no burst outstanding
// ---------------------------------------------------------------------------
module mem_sched_mc #(
    parameter int NUM_WR_CH = 2,
    parameter int NUM_RD_CH = 2,
    parameter int RD_BURST  = 4,
    parameter int TAG_DEPTH = 4,
    localparam int MAX_CH   = (NUM_WR_CH > NUM_RD_CH) ? NUM_WR_CH : NUM_RD_CH,
    localparam int CHW      = (MAX_CH > 1) ? $clog2(MAX_CH) : 1,
    localparam int BW       = (RD_BURST > 1) ? $clog2(RD_BURST) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic [NUM_WR_CH-1:0] w_req,
    input  logic [NUM_RD_CH-1:0] r_req,
    input  logic                 mem_app_rdy,
    input  logic                 mem_wr_rdy,
    input  logic                 mem_rd_rdy,
    output logic                 app_en,
    output logic [2:0]           cmd,
    output logic                 mem_wr,
    output logic                 mem_rd,
    output logic [NUM_WR_CH-1:0] wr_grant,
    output logic [NUM_RD_CH-1:0] rd_grant,
    output logic [BW-1:0]        rd_addr_num,
    output logic [BW-1:0]        rd_valid_num,
    output logic [CHW-1:0]       rd_valid_ch,
    output logic                 rd_last,
    output logic                 rd_err
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0]    CMD_WRITE = 3'b000;
    localparam logic [2:0]    CMD_READ  = 3'b001;
    localparam logic [BW-1:0] BEAT_LAST = BW'(RD_BURST - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCH_WR = 2'b01,
        ST_SCH_RD = 2'b10
    } state_t;

    typedef enum logic {
        CLS_WRITE = 1'b0,
        CLS_READ  = 1'b1
    } cls_t;

    // Round-robin search: first requesting channel starting at 'start',
    // wrapping at n. The start pointer holds (last granted channel + 1), so
    // a start of 0 after reset makes channel 0 the first winner.
    function automatic logic [CHW-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                               input logic [CHW-1:0]    start,
                                               input int                n);
        logic [CHW-1:0]    pick;
        logic              found;
        logic [MAX_CH-1:0] shifted;
        int                idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = int'(start) + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            shifted = req >> idx;
            if ((k < n) && !found && shifted[0]) begin
                pick  = CHW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Channel following 'ch' in a ring of n channels.
    function automatic logic [CHW-1:0] rr_next(input logic [CHW-1:0] ch,
                                               input int             n);
        int nxt;
        nxt = int'(ch) + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return CHW'(nxt);
    endfunction

    state_t          state_q, state_d;
    cls_t            last_cls_q, last_cls_d;
    logic [CHW-1:0]  sel_ch_q, sel_ch_d;
    logic [CHW-1:0]  wr_rr_q, wr_rr_d;
    logic [CHW-1:0]  rd_rr_q, rd_rr_d;
    logic [BW-1:0]   rd_addr_num_q, rd_addr_num_d;
    logic [BW-1:0]   rd_valid_num_q, rd_valid_num_d;
    logic [CHW-1:0]  tag_mem_q [TAG_DEPTH];
    logic [CHW-1:0]  tag_mem_d [TAG_DEPTH];
    logic [AW-1:0]   tag_wp_q, tag_wp_d;
    logic [AW-1:0]   tag_rp_q, tag_rp_d;
    logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
    logic            rd_err_q, rd_err_d;

    logic            tag_empty_s;
    logic            tag_full_s;
    logic            tag_push_s;
    logic            tag_pop_s;
    logic            any_wr_s;
    logic            any_rd_s;
    logic            app_en_s;
    logic [2:0]      cmd_s;
    logic            mem_wr_s;
    logic            mem_rd_s;
    logic [NUM_WR_CH-1:0] wr_grant_s;
    logic [NUM_RD_CH-1:0] rd_grant_s;

    assign tag_empty_s = (tag_cnt_q == {CW{1'b0}});
    assign tag_full_s  = (tag_cnt_q == CNT_FULL);
    assign any_wr_s    = |w_req;
    // A read may only be scheduled while there is room to record its tag.
    assign any_rd_s    = (|r_req) & ~tag_full_s;

    // Scheduler FSM: next state, arbitration and command-side outputs.
    always_comb begin
        state_d       = state_q;
        last_cls_d    = last_cls_q;
        sel_ch_d      = sel_ch_q;
        wr_rr_d       = wr_rr_q;
        rd_rr_d       = rd_rr_q;
        rd_addr_num_d = rd_addr_num_q;
        app_en_s      = 1'b0;
        cmd_s         = CMD_WRITE;
        mem_wr_s      = 1'b0;
        wr_grant_s    = {NUM_WR_CH{1'b0}};
        rd_grant_s    = {NUM_RD_CH{1'b0}};
        tag_push_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (freeze) begin
                    state_d = ST_IDLE;
                end else if (any_wr_s && (!any_rd_s || (last_cls_q == CLS_READ))) begin
                    // Writes win when alone, or when both classes compete
                    // and reads were served last.
                    state_d  = ST_SCH_WR;
                    sel_ch_d = rr_pick(MAX_CH'(w_req), wr_rr_q, NUM_WR_CH);
                end else if (any_rd_s) begin
                    state_d  = ST_SCH_RD;
                    sel_ch_d = rr_pick(MAX_CH'(r_req), rd_rr_q, NUM_RD_CH);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCH_WR: begin
                app_en_s = ~freeze;
                cmd_s    = CMD_WRITE;
                if (mem_app_rdy && mem_wr_rdy && !freeze) begin
                    mem_wr_s   = 1'b1;
                    wr_grant_s = NUM_WR_CH'(1'b1) << sel_ch_q;
                    last_cls_d = CLS_WRITE;
                    wr_rr_d    = rr_next(sel_ch_q, NUM_WR_CH);
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_SCH_WR;
                end
            end
            ST_SCH_RD: begin
                app_en_s = ~freeze;
                cmd_s    = CMD_READ;
                if (mem_app_rdy && !freeze) begin
                    if (rd_addr_num_q == BEAT_LAST) begin
                        rd_addr_num_d = {BW{1'b0}};
                        tag_push_s    = 1'b1;
                        rd_grant_s    = NUM_RD_CH'(1'b1) << sel_ch_q;
                        last_cls_d    = CLS_READ;
                        rd_rr_d       = rr_next(sel_ch_q, NUM_RD_CH);
                        state_d       = ST_IDLE;
                    end else begin
                        rd_addr_num_d = rd_addr_num_q + BEAT_ONE;
                    end
                end else begin
                    state_d = ST_SCH_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read return path: beat counting, tag FIFO bookkeeping and error flag.
    always_comb begin
        mem_rd_s       = mem_rd_rdy & ~tag_empty_s;
        tag_pop_s      = 1'b0;
        rd_valid_num_d = rd_valid_num_q;
        tag_mem_d      = tag_mem_q;
        tag_wp_d       = tag_wp_q;
        tag_rp_d       = tag_rp_q;
        tag_cnt_d      = tag_cnt_q;
        rd_err_d       = rd_err_q | (mem_rd_rdy & tag_empty_s);
        if (mem_rd_s) begin
            if (rd_valid_num_q == BEAT_LAST) begin
                rd_valid_num_d = {BW{1'b0}};
                tag_pop_s      = 1'b1;
            end else begin
                rd_valid_num_d = rd_valid_num_q + BEAT_ONE;
            end
        end else begin
            rd_valid_num_d = rd_valid_num_q;
        end
        if (tag_push_s) begin
            tag_mem_d[tag_wp_q] = sel_ch_q;
            tag_wp_d            = tag_wp_q + PTR_ONE;
        end else begin
            tag_wp_d = tag_wp_q;
        end
        if (tag_pop_s) begin
            tag_rp_d = tag_rp_q + PTR_ONE;
        end else begin
            tag_rp_d = tag_rp_q;
        end
        // A simultaneous push and pop leaves occupancy unchanged.
        case ({tag_push_s, tag_pop_s})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // State, counter and tag FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_cls_q     <= CLS_READ;
            sel_ch_q       <= {CHW{1'b0}};
            wr_rr_q        <= {CHW{1'b0}};
            rd_rr_q        <= {CHW{1'b0}};
            rd_addr_num_q  <= {BW{1'b0}};
            rd_valid_num_q <= {BW{1'b0}};
            tag_wp_q       <= {AW{1'b0}};
            tag_rp_q       <= {AW{1'b0}};
            tag_cnt_q      <= {CW{1'b0}};
            rd_err_q       <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= {CHW{1'b0}};
            end
        end else begin
            state_q        <= state_d;
            last_cls_q     <= last_cls_d;
            sel_ch_q       <= sel_ch_d;
            wr_rr_q        <= wr_rr_d;
            rd_rr_q        <= rd_rr_d;
            rd_addr_num_q  <= rd_addr_num_d;
            rd_valid_num_q <= rd_valid_num_d;
            tag_wp_q       <= tag_wp_d;
            tag_rp_q       <= tag_rp_d;
            tag_cnt_q      <= tag_cnt_d;
            rd_err_q       <= rd_err_d;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= tag_mem_d[i];
            end
        end
    end

    assign app_en       = app_en_s;
    assign cmd          = cmd_s;
    assign mem_wr       = mem_wr_s;
    assign mem_rd       = mem_rd_s;
    assign wr_grant     = wr_grant_s;
    assign rd_grant     = rd_grant_s;
    assign rd_addr_num  = rd_addr_num_q;
    assign rd_valid_num = rd_valid_num_q;
    assign rd_valid_ch  = tag_mem_q[tag_rp_q];
    assign rd_last      = mem_rd_s & (rd_valid_num_q == BEAT_LAST);
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_mem_sched_mc.sv
// ---------------------------------------------------------------------------
// tb_mem_sched_mc
//  Randomised scoreboard bench for mem_sched_mc. A transaction-level model
//  predicts per-cycle command outputs, grant events and labelled read beats.
//  It pushes them into queues, and a separate monitor pops and compares them
//  against what the DUT presents.
// ---------------------------------------------------------------------------
module tb_mem_sched_mc;

    localparam int NW  = 2;
    localparam int NR  = 2;
    localparam int RB  = 4;
    localparam int TD  = 4;
    localparam int CHW = 1;
    localparam int BW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          freeze = 1'b0;
    logic [NW-1:0] w_req = '0;
    logic [NR-1:0] r_req = '0;
    logic          mem_app_rdy = 1'b0;
    logic          mem_wr_rdy = 1'b0;
    logic          mem_rd_rdy = 1'b0;
    logic          app_en;
    logic [2:0]    cmd;
    logic          mem_wr;
    logic          mem_rd;
    logic [NW-1:0] wr_grant;
    logic [NR-1:0] rd_grant;
    logic [BW-1:0] rd_addr_num;
    logic [BW-1:0] rd_valid_num;
    logic [CHW-1:0] rd_valid_ch;
    logic          rd_last;
    logic          rd_err;

    mem_sched_mc #(.NUM_WR_CH(NW), .NUM_RD_CH(NR), .RD_BURST(RB), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .w_req(w_req), .r_req(r_req),
        .mem_app_rdy(mem_app_rdy), .mem_wr_rdy(mem_wr_rdy), .mem_rd_rdy(mem_rd_rdy),
        .app_en(app_en), .cmd(cmd), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .rd_addr_num(rd_addr_num),
        .rd_valid_num(rd_valid_num), .rd_valid_ch(rd_valid_ch), .rd_last(rd_last),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_rd; int ch; int cyc; } grant_t;
    typedef struct { int ch; int idx; int cyc; } beat_t;
    typedef struct { bit app_en; int cmd; bit mem_wr; bit mem_rd; bit last; int addr; bit err; } cyc_t;

    grant_t exp_grant[$];
    beat_t  exp_beat[$];
    cyc_t   exp_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_on = 1'b0;

    // Transaction-level model state
    bit m_busy, m_cur_rd, m_last_rd, m_err;
    int m_cur_ch, m_issued, m_wr_start, m_rd_start, m_beat;
    int m_out[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cur_rd = 0; m_last_rd = 1; m_err = 0;
        m_cur_ch = 0; m_issued = 0; m_wr_start = 0; m_rd_start = 0; m_beat = 0;
        m_out.delete();
        exp_grant.delete();
        exp_beat.delete();
        exp_cyc.delete();
    endtask

    function automatic int rr(input logic [3:0] req, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (start + k) % n;
            if (req[i]) return i;
        end
        return start;
    endfunction

    function automatic int first_bit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: predicts this cycle's responses, then advances to the next cycle
    bit mv_wr_any, mv_rd_any, mv_mrd, mv_acc;
    cyc_t mv_e;
    beat_t mv_b;
    grant_t mv_g;
    always @(negedge clk) begin
        if (model_on) begin
            mv_mrd    = mem_rd_rdy && (m_out.size() != 0);
            mv_rd_any = (r_req != 0) && (m_out.size() < TD);
            mv_wr_any = (w_req != 0);
            mv_acc    = m_busy && !freeze && mem_app_rdy && (m_cur_rd || mem_wr_rdy);
            mv_e.app_en = m_busy && !freeze;
            mv_e.cmd    = (m_busy && m_cur_rd) ? 1 : 0;
            mv_e.mem_wr = mv_acc && !m_cur_rd;
            mv_e.mem_rd = mv_mrd;
            mv_e.last   = mv_mrd && (m_beat == RB - 1);
            mv_e.addr   = m_issued;
            mv_e.err    = m_err;
            exp_cyc.push_back(mv_e);
            if (mv_mrd) begin
                mv_b.ch = m_out[0]; mv_b.idx = m_beat; mv_b.cyc = cyc;
                exp_beat.push_back(mv_b);
                if (m_beat == RB - 1) begin
                    m_beat = 0;
                    void'(m_out.pop_front());
                end else begin
                    m_beat++;
                end
            end else if (mem_rd_rdy) begin
                m_err = 1;
            end
            if (!m_busy) begin
                if (!freeze && (mv_wr_any || mv_rd_any)) begin
                    m_cur_rd = mv_rd_any && (!mv_wr_any || !m_last_rd);
                    m_cur_ch = m_cur_rd ? rr(4'(r_req), m_rd_start, NR) : rr(4'(w_req), m_wr_start, NW);
                    m_busy   = 1;
                    m_issued = 0;
                end
            end else if (mv_acc) begin
                if (m_cur_rd) begin
                    if (m_issued == RB - 1) begin
                        mv_g.is_rd = 1; mv_g.ch = m_cur_ch; mv_g.cyc = cyc;
                        exp_grant.push_back(mv_g);
                        m_out.push_back(m_cur_ch);
                        m_rd_start = (m_cur_ch + 1) % NR;
                        m_last_rd = 1; m_busy = 0; m_issued = 0;
                    end else begin
                        m_issued++;
                    end
                end else begin
                    mv_g.is_rd = 0; mv_g.ch = m_cur_ch; mv_g.cyc = cyc;
                    exp_grant.push_back(mv_g);
                    m_wr_start = (m_cur_ch + 1) % NW;
                    m_last_rd = 0; m_busy = 0;
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the predicted queues
    cyc_t mon_e;
    grant_t mon_g;
    beat_t mon_b;
    always @(negedge clk) begin
        #1;
        if (model_on) begin
            if (exp_cyc.size() == 0) begin
                check("cycle_record_present", 0, 1);
            end else begin
                mon_e = exp_cyc.pop_front();
                check("app_en", app_en, mon_e.app_en);
                check("cmd", cmd, mon_e.cmd);
                check("mem_wr", mem_wr, mon_e.mem_wr);
                check("mem_rd", mem_rd, mon_e.mem_rd);
                check("rd_last", rd_last, mon_e.last);
                check("rd_addr_num", rd_addr_num, mon_e.addr);
                check("rd_err", rd_err, mon_e.err);
            end
            if (wr_grant != 0 || rd_grant != 0) begin
                if (exp_grant.size() == 0) begin
                    check("grant_unexpected", {wr_grant, rd_grant}, 0);
                end else begin
                    mon_g = exp_grant.pop_front();
                    check("grant_onehot", $onehot({wr_grant, rd_grant}), 1);
                    check("grant_class", (rd_grant != 0), mon_g.is_rd);
                    check("grant_ch", first_bit(mon_g.is_rd ? 4'(rd_grant) : 4'(wr_grant)), mon_g.ch);
                    check("grant_cycle", cyc, mon_g.cyc);
                end
            end
            while (exp_grant.size() > 0 && exp_grant[0].cyc <= cyc) begin
                mon_g = exp_grant.pop_front();
                check("grant_missing_ch", 32'hFFFF, mon_g.ch);
            end
            if (mem_rd) begin
                if (exp_beat.size() == 0) begin
                    check("beat_unexpected", mem_rd, 0);
                end else begin
                    mon_b = exp_beat.pop_front();
                    check("rd_valid_ch", rd_valid_ch, mon_b.ch);
                    check("rd_valid_num", rd_valid_num, mon_b.idx);
                    check("beat_cycle", cyc, mon_b.cyc);
                end
            end
            while (exp_beat.size() > 0 && exp_beat[0].cyc <= cyc) begin
                mon_b = exp_beat.pop_front();
                check("beat_missing_idx", 32'hFFFF, mon_b.idx);
            end
        end
    end

    task automatic drive_random(input int rd_pct);
        freeze      = ($urandom_range(0, 99) < 8);
        w_req       = NW'($urandom_range(0, 3));
        r_req       = NR'($urandom_range(0, 3));
        mem_app_rdy = ($urandom_range(0, 99) < 80);
        mem_wr_rdy  = ($urandom_range(0, 99) < 75);
        mem_rd_rdy  = ($urandom_range(0, 99) < rd_pct);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_app_en"}, app_en, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_wr_grant"}, wr_grant, 0);
        check({tag, "_rd_grant"}, rd_grant, 0);
        check({tag, "_rd_addr_num"}, rd_addr_num, 0);
        check({tag, "_rd_valid_num"}, rd_valid_num, 0);
        check({tag, "_rd_valid_ch"}, rd_valid_ch, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_rd_err"}, rd_err, 0);
    endtask

    task automatic drain();
        int n;
        freeze = 0; w_req = '0; r_req = '0;
        mem_app_rdy = 1; mem_wr_rdy = 1; mem_rd_rdy = 0;
        n = 0;
        while ((m_busy || m_out.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            mem_rd_rdy = (m_out.size() != 0);
            n++;
        end
        check("drain_done", (m_busy || m_out.size() != 0), 0);
        mem_rd_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1;
        model_on = 1;
        // Reads never return at first, so the tag FIFO fills and blocks reads
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            drive_random(0);
        end
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            drive_random(35);
        end
        drain();
        // Async reset while a write command is pending
        model_on = 0;
        w_req = 2'b01; r_req = '0; mem_app_rdy = 0; mem_wr_rdy = 1; mem_rd_rdy = 1;
        repeat (2) @(posedge clk);
        #3;
        check("pre_reset_app_en", app_en, 1);
        check("pre_reset_rd_err", rd_err, 1);
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        w_req = '0; mem_rd_rdy = 0;
        @(posedge clk); #3;
        rst_n = 1;
        model_reset();
        model_on = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            drive_random(30);
        end
        drain();
        model_on = 0;
        check("leftover_grants", exp_grant.size(), 0);
        check("leftover_beats", exp_beat.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
